data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, is the number of 32-bit words of storage (power of two, minimum 4).
REQ-002 Parameter WAIT_CYCLES, default 2, is the number of wait states inserted between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address of the access.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_be  input  4  byte enables for writes; bit i enables wdata[8i+7:8i].
REQ-010 req_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  response is valid.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  read data (0 for writes and error responses).
REQ-014 rsp_err  output  1  access was rejected; storage unchanged.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 in IDLE only; a request is accepted on a cycle with req_valid=1 and req_ready=1.
REQ-017 On acceptance, addr, we, be and wdata SHALL be latched, and inputs SHALL be ignored until the next return to IDLE.
REQ-018 On acceptance, the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES, or directly to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the cycle it is 1.
REQ-020 The storage access (read capture or byte-masked write) SHALL occur on the edge entering RESP, so rsp_valid rises exactly 1+WAIT_CYCLES cycles after acceptance.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL stay stable until rsp_ready=1; the FSM then returns to IDLE on that edge.
REQ-022 A new request SHALL NOT be accepted in the same cycle a response completes (minimum one IDLE cycle between transactions).
REQ-023 The word index SHALL be req_addr[31:2]; an index >= DEPTH_WORDS SHALL produce rsp_err=1, rsp_rdata=0 and no write (no wrap-around).
REQ-024 A write with req_be=4'b0000 SHALL complete normally with rsp_err=0 and no storage change.
REQ-025 Reads SHALL return the full 32-bit word regardless of req_be.

Reset
REQ-026 While rst_n=0, the FSM SHALL be IDLE, the counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 req_ready SHALL assert on the first clock edge after rst_n deasserts.
REQ-028 Reset during WAIT SHALL drop the pending write (storage unchanged); reset during RESP SHALL discard the response.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro DMEM_MISALIGN_CHECK_EN defined, an access with req_addr[1:0] != 0 SHALL respond with rsp_err=1, rsp_rdata=0 and no write, using normal latency.
REQ-031 Without DMEM_MISALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and the access SHALL proceed on the aligned word.

Structure
REQ-032 The shared package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the word/byte-enable width constants.
REQ-033 Storage SHALL live in one sub-module, dmem_array: synchronous write with byte enables and a registered read.

Verification
REQ-034 WAIT_CYCLES=2: write addr 0x10, be 4'hF, wdata 0xDEADBEEF, then read addr 0x10 -> rsp_valid 3 cycles after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-035 Byte enables: after REQ-034, write 0x10, be 4'b0010, wdata 0x0000AA00, then read -> 0xDEADAAEF.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable, req_ready stays 0, and there is exactly one handshake when rsp_ready rises.
REQ-037 Out of range: DEPTH_WORDS=256, read 0x400 -> err 1, rdata 0; write 0x400 then read 0x0 -> word 0 unchanged.
REQ-038 Reset mid-WAIT: assert rst_n=0 one cycle after accepting a write 0x55555555 to 0x20 -> rsp_valid never rises, and a later read of 0x20 returns the old value.
REQ-039 Macro on: read 0x12 -> err 1. Macro off: read 0x12 -> data of word 0x10, err 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and FSM state encoding for the data memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-masked write and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic                           wr_en,
    input  logic [BE_W-1:0]                wr_be,
    input  logic [WORD_W-1:0]              wr_data,
    input  logic                           rd_en,
    input  logic                           rd_zero,
    output logic [WORD_W-1:0]              rd_data
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read register doubles as the response data holder; rd_zero forces 0 for writes and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with programmable wait states.
// Optional macro DMEM_MISALIGN_CHECK_EN rejects accesses with req_addr[1:0] != 0.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               enter_resp;

    logic [29:0]        widx_q;
    logic               we_q;
    logic [BE_W-1:0]    be_q;
    logic [WORD_W-1:0]  wdata_q;

    logic [29:0]        acc_widx;
    logic               acc_we;
    logic [BE_W-1:0]    acc_be;
    logic [WORD_W-1:0]  acc_wdata;
    logic               acc_oor;
    logic               acc_misalign;
    logic               acc_reject;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= (state_d == ST_IDLE);
            rsp_valid <= (state_d == ST_RESP);
            if (enter_resp) begin
                rsp_err <= acc_reject;
            end
        end
    end

    // Request capture; inputs are ignored until the FSM is back in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            widx_q  <= req_addr[31:2];
            we_q    <= req_we;
            be_q    <= req_be;
            wdata_q <= req_wdata;
        end
    end

    // With zero wait states the access happens on the accept edge, before capture lands
    assign acc_widx  = accept ? req_addr[31:2] : widx_q;
    assign acc_we    = accept ? req_we         : we_q;
    assign acc_be    = accept ? req_be         : be_q;
    assign acc_wdata = accept ? req_wdata      : wdata_q;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= |req_addr[1:0];
        end
    end

    assign acc_misalign = accept ? (|req_addr[1:0]) : misalign_q;
`else
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[1:0];
    assign acc_misalign     = 1'b0;
`endif

    assign acc_oor    = ({2'b00, acc_widx} >= 32'(DEPTH_WORDS));
    assign acc_reject = acc_oor | acc_misalign;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx     (acc_widx[AW-1:0]),
        .wr_en   (enter_resp && acc_we && !acc_reject),
        .wr_be   (acc_be),
        .wr_data (acc_wdata),
        .rd_en   (enter_resp),
        .rd_zero (acc_we || acc_reject),
        .rd_data (rsp_rdata)
    );

endmodule
